// File: rtl/bit_round_pkg.sv
// Shared definitions for the bit-serial round controller: defaults, FSM encoding
// and the wait-counter width helper.
package bit_round_pkg;

  localparam int unsigned NUM_BITS_DEF = 25;
  localparam int unsigned LANES_DEF    = 64;
  localparam int unsigned TIMEOUT_DEF  = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_DONE   = 3'd6
  } round_state_t;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int unsigned WAIT_CNT_W = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/round_wait_timer.sv
// Loadable up-counter with clear and enable; tc flags the last count before TERM.
module round_wait_timer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TERM  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  // High while the next enabled increment would reach TERM.
  assign tc = (count == WIDTH'(TERM - 1));

endmodule

// File: rtl/bit_round_controller.sv
// Sequences NUM_BITS bit-serial rounds (launch, wait for column, load) and a final
// write-to-file pulse; column capture and all outputs are registered.
module bit_round_controller
  import bit_round_pkg::*;
#(
  parameter int unsigned NUM_BITS = NUM_BITS_DEF,
  parameter int unsigned LANES    = LANES_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             col_valid,
  input  logic [LANES-1:0] col_in,
  output logic             round_start,
  output logic             ldn,
  output logic [31:0]      number,
  output logic [LANES-1:0] nIn,
  output logic             writeToFile,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int unsigned WAIT_W = cnt_width(TIMEOUT);
  localparam logic [31:0] LAST   = 32'(NUM_BITS - 1);

  round_state_t state;
  logic         wait_clr;
  logic         wait_en;
  logic         wait_tc;

  assign wait_clr = (state == ST_LAUNCH);
  assign wait_en  = (state == ST_WAIT) && !col_valid;

  round_wait_timer #(
    .WIDTH (WAIT_W),
    .TERM  (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (wait_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (wait_en),
    .tc       (wait_tc)
  );

  // Pulses are asserted on entry to their state so they are registered and
  // visible for exactly the one cycle spent in that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      round_start <= 1'b0;
      ldn         <= 1'b0;
      number      <= '0;
      nIn         <= '0;
      writeToFile <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      round_start <= 1'b0;
      ldn         <= 1'b0;
      writeToFile <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state       <= ST_LAUNCH;
              round_start <= 1'b1;
              number      <= '0;
              busy        <= 1'b1;
              done        <= 1'b0;
              timeout_err <= 1'b0;
            end
          end
          ST_LAUNCH: state <= ST_WAIT;
          ST_WAIT: begin
            if (col_valid) begin
              nIn   <= col_in;
              ldn   <= 1'b1;
              state <= ST_LOAD;
            end else if (wait_tc) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_IDLE;
            end
          end
          ST_LOAD: state <= ST_NEXT;
          ST_NEXT: begin
            if (number == LAST) begin
              writeToFile <= 1'b1;
              state       <= ST_FLUSH;
            end else begin
              number      <= number + 32'd1;
              round_start <= 1'b1;
              state       <= ST_LAUNCH;
            end
          end
          ST_FLUSH: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bit_round_controller.md
Name: bit_round_controller

Overview:
- Sequences the 64-lane bit-serial computation that fills the result register bank. The bank is 64 entries × 25 bits; each round writes one bit column.
- Runs NUM_BITS rounds. Each round launches the lane datapath, waits for its 64-bit column, then issues the load pulse with the bit index (MSB first).
- After the last column it issues a single write-to-file pulse, then reports done.
- Sits between the top-level testbench/driver and the lane datapath plus result register bank.

Parameters:
- NUM_BITS, 25, number of result bits per lane, which is the number of rounds.
- LANES, 64, number of lanes; width of the column bus.
- TIMEOUT, 255, maximum cycles to wait for the datapath column before the error abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a full NUM_BITS-round run; ignored unless IDLE.
- abort  in  1  synchronous abort; returns the FSM to IDLE and discards the run.
- col_valid  in  1  datapath: column for the current round is ready (level, sampled in WAIT).
- col_in  in  LANES  datapath column bits, lane n at bit n.
- round_start  out  1  one-cycle pulse launching the datapath for round `number`.
- ldn  out  1  one-cycle load strobe to the register bank.
- number  out  32  bit index of the current round, 0..NUM_BITS-1; the bank writes bit (24 - number).
- nIn  out  LANES  registered copy of col_in, valid while ldn=1.
- writeToFile  out  1  one-cycle pulse after the final load.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE; cleared by the next start.
- timeout_err  out  1  sticky error flag; cleared by start or reset.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0, including number=0, nIn=0, wait counter=0 and timeout_err=0.
- FSM states: IDLE, LAUNCH, WAIT, LOAD, NEXT, FLUSH, DONE.
- IDLE: on start, go to LAUNCH with number=0, done=0 and timeout_err=0.
- LAUNCH: round_start=1 for exactly one cycle. Clear the wait counter. Go to WAIT.
- WAIT:
  - col_valid=1: capture col_in into nIn and go to LOAD.
  - Otherwise increment the wait counter.
  - Counter reaching TIMEOUT: set timeout_err, go to IDLE, do not pulse writeToFile.
- LOAD: ldn=1 for exactly one cycle. number and nIn are stable during this cycle. Go to NEXT.
- NEXT:
  - number == NUM_BITS-1: go to FLUSH, number holds.
  - Otherwise number += 1 and go to LAUNCH.
- FLUSH: writeToFile=1 for one cycle. Go to DONE.
- DONE: done=1. A new start goes to LAUNCH exactly as from IDLE.
- Round latency: minimum 4 cycles per round (LAUNCH, WAIT with col_valid already high, LOAD, NEXT).
  - Best-case full run: start to writeToFile = 4·NUM_BITS + 1 cycles (101 at default).
- Outputs are registered and glitch-free. ldn, round_start and writeToFile are never high in the same cycle.
- Simultaneous events:
  - abort has priority over every transition, including col_valid in WAIT and the final NEXT.
  - abort during FLUSH still completes the writeToFile pulse for that cycle, then goes to IDLE.
  - start while busy is ignored. start and abort in the same IDLE cycle: abort wins, stay IDLE.
- number never exceeds NUM_BITS-1. There is no wrap; reset to 0 happens only on start.
- Reset mid-run: immediate return to IDLE. ldn, round_start and writeToFile drop asynchronously. The register bank contents are not this block's concern.

Decomposition:
- Shared package `bit_round_pkg`: state encoding (3-bit enum constants), NUM_BITS/LANES/TIMEOUT defaults, width of the wait counter ($clog2(TIMEOUT+1)).
- One natural sub-module: `round_wait_timer`. It is a loadable up-counter with clear, enable and a terminal-count flag, used for the WAIT timeout.
- FSM and column capture stay in the top.

Test Plan:
- Reset behaviour: hold rst=0 for 3 cycles mid-WAIT -> all outputs 0 and state IDLE; after release, col_valid=1 alone causes no ldn.
- Nominal run, col_valid tied high, col_in = round index replicated: start -> 25 ldn pulses with number 0..24 in order; writeToFile at cycle 101 after start; done=1 next cycle.
- Lane data check, col_in = 64'hA5A5_..._A5 on even rounds and its inverse on odd rounds:
  - nIn matches the captured value on every ldn.
  - Bank model entry 0 reads 25'b1010101010101010101010101.
- Datapath stall, col_valid raised 10 cycles after round_start on round 7 -> ldn 1 cycle after capture; no extra round_start; number stays 7 throughout.
- Timeout, col_valid never asserted on round 3 -> timeout_err=1 after TIMEOUT cycles in WAIT; state IDLE; writeToFile never pulses; next start clears timeout_err.
- Abort and priority:
  - abort coincident with col_valid in round 12 -> no ldn, IDLE.
  - start while busy -> ignored, number sequence uninterrupted.
  - abort in FLUSH -> one writeToFile pulse, then IDLE with done=0.
